// File: rtl/branch_resolve_unit_if.sv
// Bundles the fetch push port, the execute resolve port and the
// predictor-training / redirect / statistics outputs of branch_resolve_unit.
//
// Handshake: a push transfers on a rising clk edge when push_valid and
// push_ready are both high (and no flush happens in that cycle). A resolve
// transfers when res_valid is high and the queue is non-empty. The resolve
// side has no ready: execute only offers a resolve for a branch it knows is
// in flight. upd_en and mispredict are one-cycle pulses that need no
// acknowledgement.
interface branch_resolve_unit_if #(
    parameter int PTR_BITS = 2
);
    logic                push_valid;
    logic [31:0]         push_pc;
    logic                push_pred;
    logic [31:0]         push_target;
    logic                push_ready;
    logic                res_valid;
    logic                res_taken;
    logic [31:0]         res_target;
    logic                upd_en;
    logic [31:0]         upd_pc;
    logic                upd_val;
    logic                mispredict;
    logic [31:0]         redirect_pc;
    logic [PTR_BITS:0]   count;
    logic [31:0]         br_total;
    logic [31:0]         br_miss;

    // Fetch/execute side: drives push and resolve, observes the results.
    modport master (
        output push_valid, push_pc, push_pred, push_target,
        output res_valid, res_taken, res_target,
        input  push_ready, upd_en, upd_pc, upd_val, mispredict,
        input  redirect_pc, count, br_total, br_miss
    );

    // The branch resolve unit itself.
    modport slave (
        input  push_valid, push_pc, push_pred, push_target,
        input  res_valid, res_taken, res_target,
        output push_ready, upd_en, upd_pc, upd_val, mispredict,
        output redirect_pc, count, br_total, br_miss
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// In-order queue of predicted conditional branches. Resolving the oldest
// entry trains the predictor, detects direction/target mispredictions, and
// on a mispredict redirects fetch and discards every in-flight entry.
module branch_resolve_unit #(
    parameter int DEPTH    = 4,
    parameter int PTR_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    branch_resolve_unit_if.slave  bus
);
    localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS + 1)'(DEPTH);

    // Queue payload: no reset needed, only slots below count are ever read.
    logic [31:0]         pc_mem     [DEPTH];
    logic                pred_mem   [DEPTH];
    logic [31:0]         target_mem [DEPTH];

    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [PTR_BITS:0]   count_q;

    logic                upd_en_q;
    logic [31:0]         upd_pc_q;
    logic                upd_val_q;
    logic                mispredict_q;
    logic [31:0]         redirect_pc_q;
    logic [31:0]         br_total_q;
    logic [31:0]         br_miss_q;

    logic                push_ready;
    logic                res_accept;
    logic                push_accept;
    logic                head_pred;
    logic [31:0]         head_pc;
    logic [31:0]         head_target;
    logic                miss;
    logic [31:0]         next_pc;

    // Full means no push this cycle, even if a resolve frees a slot now.
    assign push_ready  = (count_q != FULL_COUNT);
    assign res_accept  = bus.res_valid && (count_q != '0);

    assign head_pc     = pc_mem[rd_ptr];
    assign head_pred   = pred_mem[rd_ptr];
    assign head_target = target_mem[rd_ptr];

    // Mispredict detection and redirect target for the resolving entry.
    always_comb begin
        miss    = 1'b0;
        next_pc = head_pc + 32'd4;
        if (res_accept) begin
            if (head_pred != bus.res_taken) begin
                miss = 1'b1;
            end else if (head_pred && bus.res_taken && (head_target != bus.res_target)) begin
                miss = 1'b1;
            end
        end
        if (bus.res_taken) begin
            next_pc = bus.res_target;
        end
    end

    // A push arriving with a flush is on the wrong path and is dropped.
    assign push_accept = bus.push_valid && push_ready && !miss;

    // Write the accepted push into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (push_accept) begin
            pc_mem[wr_ptr]     <= bus.push_pc;
            pred_mem[wr_ptr]   <= bus.push_pred;
            target_mem[wr_ptr] <= bus.push_target;
        end
    end

    // Pointers and occupancy; a flush empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (reset || miss) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (res_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_accept, res_accept})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Registered training/redirect outputs; payload holds between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            upd_en_q      <= 1'b0;
            upd_pc_q      <= '0;
            upd_val_q     <= 1'b0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            upd_en_q     <= res_accept;
            mispredict_q <= miss;
            if (res_accept) begin
                upd_pc_q      <= head_pc;
                upd_val_q     <= bus.res_taken;
                redirect_pc_q <= next_pc;
            end
        end
    end

    // Statistics counters, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            br_total_q <= '0;
            br_miss_q  <= '0;
        end else begin
            if (res_accept) begin
                br_total_q <= br_total_q + 32'd1;
            end
            if (miss) begin
                br_miss_q <= br_miss_q + 32'd1;
            end
        end
    end

    assign bus.push_ready  = push_ready;
    assign bus.upd_en      = upd_en_q;
    assign bus.upd_pc      = upd_pc_q;
    assign bus.upd_val     = upd_val_q;
    assign bus.mispredict  = mispredict_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign bus.count       = count_q;
    assign bus.br_total    = br_total_q;
    assign bus.br_miss     = br_miss_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vector table, a reset-mid-flight
// sequence, then randomized traffic against a queue-based reference model.
module tb_branch_resolve_unit;
    localparam int DEPTH    = 4;
    localparam int PTR_BITS = 2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.PTR_BITS(PTR_BITS)) bus ();

    branch_resolve_unit #(.DEPTH(DEPTH), .PTR_BITS(PTR_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    int checks;
    int failures;

    typedef struct {
        logic [31:0] pc;
        logic        pred;
        logic [31:0] target;
    } entry_t;

    entry_t      mq[$];
    logic        m_upd_en;
    logic [31:0] m_upd_pc;
    logic        m_upd_val;
    logic        m_mis;
    logic [31:0] m_rpc;
    logic [31:0] m_tot;
    logic [31:0] m_miss;
    logic        pre_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour for one clock edge, from the unit's rules.
    task automatic model_edge(input logic rst, input logic pv, input logic [31:0] pc,
                              input logic pred, input logic [31:0] tgt, input logic rv,
                              input logic tk, input logic [31:0] rtgt);
        entry_t e;
        logic   ready;
        logic   racc;
        logic   miss;
        if (rst) begin
            mq.delete();
            m_upd_en = 0; m_upd_pc = 0; m_upd_val = 0; m_mis = 0; m_rpc = 0;
            m_tot = 0; m_miss = 0;
            return;
        end
        ready = (mq.size() != DEPTH);
        racc  = rv && (mq.size() > 0);
        miss  = 0;
        m_upd_en = racc;
        if (racc) begin
            e = mq[0];
            miss = (e.pred != tk) || (e.pred && tk && (e.target != rtgt));
            m_upd_pc  = e.pc;
            m_upd_val = tk;
            m_rpc     = tk ? rtgt : e.pc + 32'd4;
            m_tot     = m_tot + 1;
            if (miss) m_miss = m_miss + 1;
        end
        m_mis = miss;
        if (miss) begin
            mq.delete();
        end else begin
            if (racc) void'(mq.pop_front());
            if (pv && ready) begin
                e.pc = pc; e.pred = pred; e.target = tgt;
                mq.push_back(e);
            end
        end
    endtask

    // ---------------- driver ----------------
    // Drive one cycle's inputs, sample push_ready, clock, compare to model.
    task automatic cycle(input logic rst, input logic pv, input logic [31:0] pc,
                         input logic pred, input logic [31:0] tgt, input logic rv,
                         input logic tk, input logic [31:0] rtgt);
        reset           = rst;
        bus.push_valid  = pv;
        bus.push_pc     = pc;
        bus.push_pred   = pred;
        bus.push_target = tgt;
        bus.res_valid   = rv;
        bus.res_taken   = tk;
        bus.res_target  = rtgt;
        #1;
        pre_ready = bus.push_ready;
        if (!rst) check("push_ready_model", {31'd0, pre_ready}, {31'd0, mq.size() != DEPTH});
        model_edge(rst, pv, pc, pred, tgt, rv, tk, rtgt);
        @(posedge clk);
        #1;
        check("upd_en_model",      {31'd0, bus.upd_en},     {31'd0, m_upd_en});
        check("upd_pc_model",      bus.upd_pc,              m_upd_pc);
        check("upd_val_model",     {31'd0, bus.upd_val},    {31'd0, m_upd_val});
        check("mispredict_model",  {31'd0, bus.mispredict}, {31'd0, m_mis});
        check("redirect_pc_model", bus.redirect_pc,         m_rpc);
        check("count_model",       32'(bus.count),          32'(mq.size()));
        check("br_total_model",    bus.br_total,            m_tot);
        check("br_miss_model",     bus.br_miss,             m_miss);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        pv;
        logic [31:0] pc;
        logic        pred;
        logic [31:0] tgt;
        logic        rv;
        logic        tk;
        logic [31:0] rtgt;
        logic        e_rdy;
        logic        e_ue;
        logic [31:0] e_upc;
        logic        e_uval;
        logic        e_mis;
        logic [31:0] e_rpc;
        int          e_cnt;
        int          e_tot;
        int          e_miss;
    } vec_t;

    vec_t vecs[24];

    initial begin
        int rst_cycles;
        checks   = 0;
        failures = 0;

        //          pv pc        pd tgt       rv tk rtgt      rdy ue upc       uv ms rpc       cnt tot miss
        // correct not-taken
        vecs[0]  = '{1, 32'h100, 0, 32'h0,   0, 0, 32'h0,   1,  0, 32'h0,   0, 0, 32'h0,   1, 0, 0};
        vecs[1]  = '{0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   1,  1, 32'h100, 0, 0, 32'h104, 0, 1, 0};
        // direction mispredict with same-cycle wrong-path push
        vecs[2]  = '{1, 32'h200, 0, 32'h0,   0, 0, 32'h0,   1,  0, 32'h100, 0, 0, 32'h104, 1, 1, 0};
        vecs[3]  = '{1, 32'h204, 0, 32'h0,   0, 0, 32'h0,   1,  0, 32'h100, 0, 0, 32'h104, 2, 1, 0};
        vecs[4]  = '{1, 32'h208, 0, 32'h0,   0, 0, 32'h0,   1,  0, 32'h100, 0, 0, 32'h104, 3, 1, 0};
        vecs[5]  = '{1, 32'h20C, 0, 32'h0,   1, 1, 32'h400, 1,  1, 32'h200, 1, 1, 32'h400, 0, 2, 1};
        vecs[6]  = '{0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   1,  0, 32'h200, 1, 0, 32'h400, 0, 2, 1};
        // target mispredict, then predicted-taken-but-not-taken
        vecs[7]  = '{1, 32'h300, 1, 32'h500, 0, 0, 32'h0,   1,  0, 32'h200, 1, 0, 32'h400, 1, 2, 1};
        vecs[8]  = '{0, 32'h0,   0, 32'h0,   1, 1, 32'h540, 1,  1, 32'h300, 1, 1, 32'h540, 0, 3, 2};
        vecs[9]  = '{1, 32'h300, 1, 32'h500, 0, 0, 32'h0,   1,  0, 32'h300, 1, 0, 32'h540, 1, 3, 2};
        vecs[10] = '{0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   1,  1, 32'h300, 0, 1, 32'h304, 0, 4, 3};
        // correct taken with matching target
        vecs[11] = '{1, 32'h600, 1, 32'h700, 0, 0, 32'h0,   1,  0, 32'h300, 0, 0, 32'h304, 1, 4, 3};
        vecs[12] = '{0, 32'h0,   0, 32'h0,   1, 1, 32'h700, 1,  1, 32'h600, 1, 0, 32'h700, 0, 5, 3};
        // resolve while empty is ignored
        vecs[13] = '{0, 32'h0,   0, 32'h0,   1, 1, 32'h123, 1,  0, 32'h600, 1, 0, 32'h700, 0, 5, 3};
        // fill, full push dropped, pointer wrap
        vecs[14] = '{1, 32'h800, 0, 32'h0,   0, 0, 32'h0,   1,  0, 32'h600, 1, 0, 32'h700, 1, 5, 3};
        vecs[15] = '{1, 32'h804, 0, 32'h0,   0, 0, 32'h0,   1,  0, 32'h600, 1, 0, 32'h700, 2, 5, 3};
        vecs[16] = '{1, 32'h808, 0, 32'h0,   0, 0, 32'h0,   1,  0, 32'h600, 1, 0, 32'h700, 3, 5, 3};
        vecs[17] = '{1, 32'h80C, 0, 32'h0,   0, 0, 32'h0,   1,  0, 32'h600, 1, 0, 32'h700, 4, 5, 3};
        vecs[18] = '{1, 32'h810, 0, 32'h0,   1, 0, 32'h0,   0,  1, 32'h800, 0, 0, 32'h804, 3, 6, 3};
        vecs[19] = '{1, 32'h810, 0, 32'h0,   1, 0, 32'h0,   1,  1, 32'h804, 0, 0, 32'h808, 3, 7, 3};
        vecs[20] = '{1, 32'h814, 0, 32'h0,   1, 0, 32'h0,   1,  1, 32'h808, 0, 0, 32'h80C, 3, 8, 3};
        vecs[21] = '{0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   1,  1, 32'h80C, 0, 0, 32'h810, 2, 9, 3};
        vecs[22] = '{0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   1,  1, 32'h810, 0, 0, 32'h814, 1, 10, 3};
        vecs[23] = '{0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   1,  1, 32'h814, 0, 0, 32'h818, 0, 11, 3};

        // ---------------- reset ----------------
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        check("reset_count",     32'(bus.count),          32'd0);
        check("reset_ready",     {31'd0, bus.push_ready}, 32'd1);
        check("reset_upd_en",    {31'd0, bus.upd_en},     32'd0);
        check("reset_mis",       {31'd0, bus.mispredict}, 32'd0);
        check("reset_upd_pc",    bus.upd_pc,              32'd0);
        check("reset_redirect",  bus.redirect_pc,         32'd0);
        check("reset_br_total",  bus.br_total,            32'd0);
        check("reset_br_miss",   bus.br_miss,             32'd0);

        // ---------------- directed table ----------------
        for (int i = 0; i < 24; i++) begin
            cycle(0, vecs[i].pv, vecs[i].pc, vecs[i].pred, vecs[i].tgt,
                  vecs[i].rv, vecs[i].tk, vecs[i].rtgt);
            check($sformatf("v%0d_push_ready", i), {31'd0, pre_ready},      {31'd0, vecs[i].e_rdy});
            check($sformatf("v%0d_upd_en", i),     {31'd0, bus.upd_en},     {31'd0, vecs[i].e_ue});
            check($sformatf("v%0d_upd_pc", i),     bus.upd_pc,              vecs[i].e_upc);
            check($sformatf("v%0d_upd_val", i),    {31'd0, bus.upd_val},    {31'd0, vecs[i].e_uval});
            check($sformatf("v%0d_mispredict", i), {31'd0, bus.mispredict}, {31'd0, vecs[i].e_mis});
            check($sformatf("v%0d_redirect", i),   bus.redirect_pc,         vecs[i].e_rpc);
            check($sformatf("v%0d_count", i),      32'(bus.count),          32'(vecs[i].e_cnt));
            check($sformatf("v%0d_br_total", i),   bus.br_total,            32'(vecs[i].e_tot));
            check($sformatf("v%0d_br_miss", i),    bus.br_miss,             32'(vecs[i].e_miss));
        end

        // ---------------- reset mid-flight ----------------
        cycle(0, 1, 32'hA00, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'hA04, 1, 32'hB00, 0, 0, 0);
        cycle(0, 1, 32'hA08, 0, 0, 0, 0, 0);
        check("midrst_pre_count", 32'(bus.count), 32'd3);
        cycle(1, 1, 32'hA0C, 0, 0, 1, 1, 32'hC00);
        check("midrst_count",    32'(bus.count),          32'd0);
        check("midrst_upd_en",   {31'd0, bus.upd_en},     32'd0);
        check("midrst_mis",      {31'd0, bus.mispredict}, 32'd0);
        check("midrst_br_total", bus.br_total,            32'd0);
        check("midrst_br_miss",  bus.br_miss,             32'd0);
        check("midrst_ready",    {31'd0, bus.push_ready}, 32'd1);

        // ---------------- randomized traffic ----------------
        rst_cycles = 0;
        for (int n = 0; n < 3000; n++) begin
            logic        r_rst;
            logic [31:0] r_pc;
            logic [31:0] r_tgt;
            logic [31:0] r_rtgt;
            r_rst  = ($urandom_range(0, 299) == 0);
            if (r_rst) rst_cycles++;
            r_pc   = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
            if ($urandom_range(0, 63) == 0) r_pc = 32'hFFFF_FFFC;
            r_tgt  = 32'h2000 + 32'($urandom_range(0, 3)) * 4;
            r_rtgt = 32'h2000 + 32'($urandom_range(0, 3)) * 4;
            cycle(r_rst,
                  logic'($urandom_range(0, 99) < 70), r_pc, logic'($urandom_range(0, 1)), r_tgt,
                  logic'($urandom_range(0, 99) < 55), logic'($urandom_range(0, 1)), r_rtgt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Tracks conditional branches between fetch (prediction) and execute (resolution). Holds every in-flight prediction in a small in-order queue. When execute resolves the oldest branch, the unit produces the one-cycle training pulse for the branch predictor (`upd_en`/`upd_pc`/`upd_val`), detects mispredictions, and issues the fetch redirect plus queue flush. It also keeps branch and mispredict statistics counters.

## Interface
Parameters:
- `DEPTH`, default 4: queue entries; must be a power of two.
- `PTR_BITS`, default 2: log2(`DEPTH`).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `push_valid`  in  1  fetch offers one predicted conditional branch.
- `push_pc`  in  32  branch PC.
- `push_pred`  in  1  predicted direction (1 = taken).
- `push_target`  in  32  predicted taken target.
- `push_ready`  out  1  queue can accept; equals `count != DEPTH`.
- `res_valid`  in  1  execute resolves the oldest in-flight branch.
- `res_taken`  in  1  actual direction.
- `res_target`  in  32  actual taken target.
- `upd_en`  out  1  predictor training pulse.
- `upd_pc`  out  32  PC of the resolved branch.
- `upd_val`  out  1  actual outcome.
- `mispredict`  out  1  redirect pulse to fetch.
- `redirect_pc`  out  32  correct next PC.
- `count`  out  `PTR_BITS`+1  current occupancy.
- `br_total`  out  32  resolved-branch counter.
- `br_miss`  out  32  mispredict counter.

## Operation
- **Queue:** circular buffer of {pc, pred, target}.
  - `wr_ptr` and `rd_ptr` are `PTR_BITS` wide and wrap modulo `DEPTH`.
  - `count` tracks occupancy, 0..`DEPTH`.
- **Push:** accepted when `push_valid && push_ready && !flush`. The entry is written at `wr_ptr`, then `wr_ptr` increments.
- **Resolve:** accepted when `res_valid && count != 0`. The entry at `rd_ptr` is the one resolved.
  - `res_valid` with `count == 0` is ignored: no outputs, no state change.
- **Misprediction** is detected when either:
  - `pred != res_taken`, or
  - `pred == 1`, `res_taken == 1` and `target != res_target`.
- **`redirect_pc`** is `res_target` if `res_taken`, else `pc + 32'd4`. The add wraps modulo 2^32.
- **Flush** is asserted in the resolving cycle when a mispredict is detected:
  - All entries are discarded: `rd_ptr <= 0`, `wr_ptr <= 0`, `count <= 0`.
  - A push in the same cycle is dropped, because it is a wrong-path branch.
- **Counters:**
  - `br_total` increments on every accepted resolve.
  - `br_miss` increments on every mispredict.
  - Both wrap at 2^32.
- **Occupancy update (no flush):** `count` += push accepted, -= resolve accepted. Simultaneous push and resolve leaves `count` unchanged.
- **Full queue:** `push_ready` is 0 even if a resolve frees a slot in the same cycle. The freed slot is usable the next cycle.

## Timing
- **Reset values:**
  - `upd_en`, `upd_val`, `mispredict` = 0.
  - `upd_pc`, `redirect_pc` = 0.
  - `count` = 0, so `push_ready` = 1.
  - `br_total`, `br_miss` = 0.
  - Both pointers = 0.
  - Queue payload is don't-care.
- **Output latency:** `upd_*`, `mispredict` and `redirect_pc` are registered and valid exactly 1 cycle after the accepted resolve. `upd_en` and `mispredict` are single-cycle pulses.
  - `upd_pc`, `upd_val` and `redirect_pc` hold their last value when not pulsing.
- **Flush visibility:** the queue is empty in the cycle after the resolve, i.e. `count` = 0 in the same cycle `mispredict` = 1.
- **Throughput:** one push and one resolve per cycle, sustained.
- **Reset mid-operation:** reset overrides every pending push and resolve. No `upd_en` or `mispredict` pulse is produced the cycle after reset.

## Test plan
- **Correct not-taken:**
  - Stimulus: push pc=0x100, pred=0; resolve taken=0.
  - Next cycle: `upd_en`=1, `upd_pc`=0x100, `upd_val`=0, `mispredict`=0; `br_total`=1, `br_miss`=0; `count`=0.
- **Direction mispredict with flush:**
  - Stimulus: push 0x200 (pred=0), 0x204, 0x208; resolve taken=1, target=0x400, together with a push of 0x20C.
  - Next cycle: `mispredict`=1, `redirect_pc`=0x400, `upd_val`=1, `count`=0; 0x20C not stored.
- **Target mispredict:**
  - Stimulus: push pc=0x300, pred=1, target=0x500; resolve taken=1, target=0x540.
  - Next cycle: `mispredict`=1, `redirect_pc`=0x540.
  - Predicted-taken-but-not-taken case gives `redirect_pc`=0x304.
- **Full and wrap:**
  - Stimulus: push 4 branches, keep `push_valid` high, then resolve the 4 correctly.
  - `push_ready`=0 while `count`=4; a concurrent push+resolve when full takes only the resolve.
  - Pointers wrap; the 5th/6th pushes reuse slots 0/1; the resolve order matches push order.
- **Empty resolve / reset mid-flight:**
  - Stimulus A: `res_valid` with `count`=0 → no pulse, counters unchanged.
  - Stimulus B: assert `reset` with 3 entries and a resolve pending → next cycle `count`=0, `upd_en`=0, `mispredict`=0, counters=0.
